// File: rtl/ama_riscv_pkg.sv
// Shared types for the unified-memory arbiter: port identifiers and the
// per-request tag that travels alongside an outstanding memory read.
package ama_riscv_pkg;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic      v;
    arb_port_e port;
    logic      kill;
  } arb_tag_t;

  localparam arb_tag_t ARB_TAG_NONE = '{v: 1'b0, port: ARB_PORT_I, kill: 1'b0};

  // Marks a tag as killed when a kill is requested for the port it belongs to.
  function automatic arb_tag_t arb_tag_kill(input arb_tag_t  tag,
                                            input logic      kill_en,
                                            input arb_port_e kill_port);
    arb_tag_t res;
    res = tag;
    if (kill_en && tag.v && (tag.port == kill_port)) begin
      res.kill = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ama_riscv_arb_tag_pipe.sv
// MEM_LAT-deep shift register of read tags. A tag entering at stage 0 emerges
// at the last stage exactly MEM_LAT cycles later, lined up with mem_rdata.
// A kill request marks every in-flight tag of the named port, including the
// one being loaded in the same cycle.
module ama_riscv_arb_tag_pipe
  import ama_riscv_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  arb_tag_t  in_tag,
  input  logic      kill_en,
  input  arb_port_e kill_port,
  output arb_tag_t  out_tag
);

  arb_tag_t stage [MEM_LAT];

  // Shift tags one stage per cycle, applying any kill on the way through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        stage[k] <= ARB_TAG_NONE;
      end
    end else begin
      stage[0] <= arb_tag_kill(in_tag, kill_en, kill_port);
      for (int k = 1; k < MEM_LAT; k++) begin
        stage[k] <= arb_tag_kill(stage[k-1], kill_en, kill_port);
      end
    end
  end

  assign out_tag = stage[MEM_LAT-1];

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch
// and load/store. Data wins by default; a fetch that has been stalled for
// STARVE_MAX cycles is let through once. Read responses are steered back to
// the requester using a tag pipe that matches the memory latency.
module ama_riscv_mem_arbiter
  import ama_riscv_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch port
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_rsp_valid,
  output logic [DW-1:0]   i_rsp_data,
  input  logic            i_flush,
  // load/store port
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_we,
  input  logic [DW/8-1:0] d_req_wmask,
  input  logic [DW-1:0]   d_req_wdata,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,
  // memory
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-3:0]   mem_addr,
  output logic [DW/8-1:0] mem_wmask,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;
  logic          starve_force;
  logic          grant_i;
  logic          grant_d;
  logic          rsp_live;
  arb_tag_t      new_tag;
  arb_tag_t      last_tag;
  logic          unused_addr_lsbs;

  // Byte offsets are irrelevant to a word-addressed memory.
  assign unused_addr_lsbs = &{1'b0, i_req_addr[1:0], d_req_addr[1:0]};

  // Pick at most one winner; reset holds both ports off so nothing leaks out.
  always_comb begin
    starve_force = i_req_valid && (starve == SW'(STARVE_MAX));
    grant_d      = !rst && d_req_valid && !starve_force;
    grant_i      = !rst && i_req_valid && !grant_d;
    i_req_ready  = grant_i;
    d_req_ready  = grant_d;
  end

  // Count how long a waiting fetch has been pushed aside by data traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (!i_req_valid || grant_i) begin
      starve <= '0;
    end else if (starve != SW'(STARVE_MAX)) begin
      starve <= starve + SW'(1);
    end
  end

  // Drive the memory from whichever port won; write fields stay 0 on reads.
  always_comb begin
    mem_en    = grant_d || grant_i;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_we   = d_req_we;
      mem_addr = d_req_addr[AW-1:2];
      if (d_req_we) begin
        mem_wmask = d_req_wmask;
        mem_wdata = d_req_wdata;
      end
    end else if (grant_i) begin
      mem_addr = i_req_addr[AW-1:2];
    end
  end

  // Build the tag for this cycle's grant; stores never expect read data.
  always_comb begin
    new_tag      = ARB_TAG_NONE;
    new_tag.v    = grant_i || (grant_d && !d_req_we);
    new_tag.port = grant_d ? ARB_PORT_D : ARB_PORT_I;
  end

  ama_riscv_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_tag    (new_tag),
    .kill_en   (i_flush),
    .kill_port (ARB_PORT_I),
    .out_tag   (last_tag)
  );

  // Route the returning read data; a flush also blocks the fetch response
  // that happens to surface in the flush cycle itself.
  always_comb begin
    rsp_live    = last_tag.v && !last_tag.kill;
    i_rsp_valid = rsp_live && (last_tag.port == ARB_PORT_I) && !i_flush;
    d_rsp_valid = rsp_live && (last_tag.port == ARB_PORT_D);
    i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
    d_rsp_data  = d_rsp_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Self-checking bench for ama_riscv_mem_arbiter. Three copies of the arbiter
// (MEM_LAT = 1, 2, 3) share the same request stimulus; index g of each output
// array belongs to the copy with MEM_LAT = g+1.
module tb_ama_riscv_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_flush;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [3:0]  d_req_wmask;
  logic [31:0] d_req_wdata;
  logic [31:0] mem_rdata;

  logic        i_req_ready [3];
  logic        i_rsp_valid [3];
  logic [31:0] i_rsp_data  [3];
  logic        d_req_ready [3];
  logic        d_rsp_valid [3];
  logic [31:0] d_rsp_data  [3];
  logic        mem_en      [3];
  logic        mem_we      [3];
  logic [29:0] mem_addr    [3];
  logic [3:0]  mem_wmask   [3];
  logic [31:0] mem_wdata   [3];

  int testsRun;
  int testsFailed;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ama_riscv_mem_arbiter #(
      .AW         (32),
      .DW         (32),
      .MEM_LAT    (g + 1),
      .STARVE_MAX (4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (i_req_valid),
      .i_req_ready (i_req_ready[g]),
      .i_req_addr  (i_req_addr),
      .i_rsp_valid (i_rsp_valid[g]),
      .i_rsp_data  (i_rsp_data[g]),
      .i_flush     (i_flush),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready[g]),
      .d_req_addr  (d_req_addr),
      .d_req_we    (d_req_we),
      .d_req_wmask (d_req_wmask),
      .d_req_wdata (d_req_wdata),
      .d_rsp_valid (d_rsp_valid[g]),
      .d_rsp_data  (d_rsp_data[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wmask   (mem_wmask[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata)
    );
  end

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        i_v;
    logic [31:0] i_addr;
    logic        d_v;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        exp_i_rdy;
    logic        exp_d_rdy;
    logic        exp_en;
    logic        exp_we;
    logic [29:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic checkBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %b required %b", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_req_valid = v.i_v;
    i_req_addr  = v.i_addr;
    d_req_valid = v.d_v;
    d_req_addr  = v.d_addr;
    d_req_we    = v.d_we;
    d_req_wmask = v.d_wmask;
    d_req_wdata = v.d_wdata;
  endtask

  task automatic idleInputs();
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_flush     = 1'b0;
    d_req_valid = 1'b0;
    d_req_addr  = '0;
    d_req_we    = 1'b0;
    d_req_wmask = '0;
    d_req_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idleInputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mem_rdata   = '0;
    idleInputs();

    //            i_v  i_addr        d_v  d_addr      we    wmask    wdata         i_r   d_r   en    mwe   addr          mask     mwdata
    vecs[0] = '{1'b0, 32'h0,        1'b0, 32'h0,     1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 30'h0,        4'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h40010, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 30'h10004,    4'h0, 32'h0};
    vecs[2] = '{1'b1, 32'h40000,    1'b0, 32'h0,     1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 30'h10000,    4'h0, 32'h0};
    vecs[3] = '{1'b1, 32'h40000,    1'b1, 32'h2000,  1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 30'h800,      4'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 32'h100,   1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 30'h40,       4'h3, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 32'h44,       1'b1, 32'h8,     1'b1, 4'hC, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 30'h2,        4'hC, 32'h12345678};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 32'h44,    1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 30'h11,       4'h0, 32'h0};
    vecs[7] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,     1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 30'h3FFFFFFF, 4'h0, 32'h0};

    // Reset state, with both requesters pushing so the gating is visible.
    rst = 1'b0;
    #1 rst = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h40000;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h40010;
    #2;
    checkBit("rst i_req_ready", i_req_ready[0], 1'b0);
    checkBit("rst d_req_ready", d_req_ready[0], 1'b0);
    checkBit("rst mem_en", mem_en[0], 1'b0);
    checkOutput("rst mem_addr", 32'(mem_addr[0]), 32'h0);
    checkBit("rst i_rsp_valid", i_rsp_valid[1], 1'b0);
    checkBit("rst d_rsp_valid", d_rsp_valid[1], 1'b0);
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle grant/mux vectors, each followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkBit($sformatf("vec%0d i_req_ready", i), i_req_ready[0], vecs[i].exp_i_rdy);
      checkBit($sformatf("vec%0d d_req_ready", i), d_req_ready[0], vecs[i].exp_d_rdy);
      checkBit($sformatf("vec%0d mem_en", i), mem_en[0], vecs[i].exp_en);
      checkBit($sformatf("vec%0d mem_we", i), mem_we[0], vecs[i].exp_we);
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(mem_addr[0]), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d mem_wmask", i), 32'(mem_wmask[0]), 32'(vecs[i].exp_wmask));
      checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata[0], vecs[i].exp_wdata);
      tick();
      idleInputs();
      tick();
    end
    drain(4);

    // Single load on the MEM_LAT=1 copy: data returns on the next cycle.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h40010;
    #2;
    checkOutput("load mem_addr", 32'(mem_addr[0]), 32'h10004);
    checkBit("load d_req_ready", d_req_ready[0], 1'b1);
    tick();
    idleInputs();
    mem_rdata = 32'hCAFE0001;
    #2;
    checkBit("load d_rsp_valid", d_rsp_valid[0], 1'b1);
    checkOutput("load d_rsp_data", d_rsp_data[0], 32'hCAFE0001);
    checkBit("load no i_rsp", i_rsp_valid[0], 1'b0);
    tick();
    #2;
    checkBit("load rsp one pulse", d_rsp_valid[0], 1'b0);
    drain(4);

    // Both ports busy: four data grants, then one forced fetch grant.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h40000;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h80;
    for (int k = 0; k < 10; k++) begin
      #2;
      checkBit($sformatf("starve c%0d d_req_ready", k), d_req_ready[0], (k % 5) != 4);
      checkBit($sformatf("starve c%0d i_req_ready", k), i_req_ready[0], (k % 5) == 4);
      tick();
    end
    drain(4);

    // Store: write strobes reach memory and no response ever comes back.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h100;
    d_req_we    = 1'b1;
    d_req_wmask = 4'b0011;
    d_req_wdata = 32'hDEADBEEF;
    #2;
    checkBit("store mem_we", mem_we[0], 1'b1);
    checkOutput("store mem_wmask", 32'(mem_wmask[0]), 32'h3);
    checkOutput("store mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    checkOutput("store mem_addr", 32'(mem_addr[0]), 32'h40);
    tick();
    idleInputs();
    for (int k = 0; k < 4; k++) begin
      #2;
      checkBit($sformatf("store no d_rsp c%0d", k), d_rsp_valid[0] | d_rsp_valid[1] | d_rsp_valid[2], 1'b0);
      tick();
    end
    drain(2);

    // Back-to-back fetches with a flush on the third one.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h40000;
    mem_rdata   = 32'h10000000;
    #2;
    checkBit("flush c0 i_req_ready", i_req_ready[1], 1'b1);
    tick();
    i_req_addr = 32'h40004;
    mem_rdata  = 32'h10000001;
    #2;
    checkBit("flush c1 lat1 i_rsp_valid", i_rsp_valid[0], 1'b1);
    checkOutput("flush c1 lat1 i_rsp_data", i_rsp_data[0], 32'h10000001);
    tick();
    i_req_addr = 32'h40008;
    i_flush    = 1'b1;
    mem_rdata  = 32'h10000002;
    #2;
    checkBit("flush c2 lat1 i_rsp_valid", i_rsp_valid[0], 1'b0);
    checkBit("flush c2 lat2 i_rsp_valid", i_rsp_valid[1], 1'b0);
    tick();
    i_req_addr = 32'h4000C;
    i_flush    = 1'b0;
    mem_rdata  = 32'h10000003;
    #2;
    checkBit("flush c3 lat1 i_rsp_valid", i_rsp_valid[0], 1'b0);
    checkBit("flush c3 lat2 i_rsp_valid", i_rsp_valid[1], 1'b0);
    tick();
    idleInputs();
    mem_rdata = 32'h10000004;
    #2;
    checkBit("flush c4 lat2 i_rsp_valid", i_rsp_valid[1], 1'b0);
    checkBit("flush c4 lat1 i_rsp_valid", i_rsp_valid[0], 1'b1);
    checkOutput("flush c4 lat1 i_rsp_data", i_rsp_data[0], 32'h10000004);
    tick();
    mem_rdata = 32'h10000005;
    #2;
    checkBit("flush c5 lat2 i_rsp_valid", i_rsp_valid[1], 1'b1);
    checkOutput("flush c5 lat2 i_rsp_data", i_rsp_data[1], 32'h10000005);
    drain(5);

    // Fetch then load on the MEM_LAT=3 copy: each answer on its own port.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h200;
    tick();
    idleInputs();
    d_req_valid = 1'b1;
    d_req_addr  = 32'h300;
    tick();
    idleInputs();
    mem_rdata = 32'h0;
    #2;
    checkBit("ilv c2 i_rsp_valid", i_rsp_valid[2], 1'b0);
    checkBit("ilv c2 d_rsp_valid", d_rsp_valid[2], 1'b0);
    tick();
    mem_rdata = 32'h11111111;
    #2;
    checkBit("ilv c3 i_rsp_valid", i_rsp_valid[2], 1'b1);
    checkOutput("ilv c3 i_rsp_data", i_rsp_data[2], 32'h11111111);
    checkBit("ilv c3 d_rsp_valid", d_rsp_valid[2], 1'b0);
    tick();
    mem_rdata = 32'h22222222;
    #2;
    checkBit("ilv c4 d_rsp_valid", d_rsp_valid[2], 1'b1);
    checkOutput("ilv c4 d_rsp_data", d_rsp_data[2], 32'h22222222);
    checkBit("ilv c4 i_rsp_valid", i_rsp_valid[2], 1'b0);
    drain(5);

    // Reset while a load is in flight on the MEM_LAT=2 copy.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h40010;
    mem_rdata   = 32'h33333333;
    #2;
    checkBit("rstmid grant", d_req_ready[1], 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkBit("rstmid d_req_ready", d_req_ready[1], 1'b0);
    checkBit("rstmid mem_en", mem_en[1], 1'b0);
    checkOutput("rstmid mem_addr", 32'(mem_addr[1]), 32'h0);
    checkBit("rstmid d_rsp_valid", d_rsp_valid[1], 1'b0);
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      checkBit($sformatf("rstmid no d_rsp c%0d", k), d_rsp_valid[0] | d_rsp_valid[1] | d_rsp_valid[2], 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
